// File: rtl/serial_alu_ctrl.sv
// -----------------------------------------------------------------------------
// serial_alu_ctrl
//
// Computes a WIDTH-bit ALU operation by driving one external 1-bit ALU slice
// for WIDTH cycles, LSB first. The slice is purely combinational. Its outputs
// are consumed in the same cycle that the slice inputs are driven. The carry
// is chained through a register between cycles. SLT is resolved from the MSB
// slice's set and overflow outputs, not from the slice's own SLT path.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             operation request, sampled only while idle
//   ctrl_i[3:0]         ALU control: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB,
//                       0111 SLT, 1100 NOR (anything else is an error)
//   src1_i, src2_i      operands A and B, captured when a request is accepted
//   busy_o              operation in progress (RUN or FIN)
//   done_o              one-cycle completion pulse
//   err_o               illegal ctrl_i, valid with done_o
//   result_o            result, held until the next completion
//   zero_o, cout_o,     result-is-zero, MSB carry out (ADD/SUB/SLT) and
//   overflow_o          signed overflow (ADD/SUB), held with result_o
//   sl_*_o              drive to the 1-bit slice (all 0 outside RUN)
//   sl_*_i              combinational outputs of the 1-bit slice
// -----------------------------------------------------------------------------
module serial_alu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o,
  output logic             sl_src1_o,
  output logic             sl_src2_o,
  output logic             sl_less_o,
  output logic             sl_ainv_o,
  output logic             sl_binv_o,
  output logic             sl_cin_o,
  output logic [1:0]       sl_op_o,
  input  logic             sl_result_i,
  input  logic             sl_cout_i,
  input  logic             sl_overflow_i,
  input  logic             sl_set_i
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // Decoded view of ctrl_i: slice controls plus how the MSB results are used.
  typedef struct packed {
    logic       legal;
    logic       ainv;
    logic       binv;
    logic [1:0] op;
    logic       cin;       // initial carry: 1 for subtract-style ops
    logic       use_cout;  // cout_o reports the MSB carry
    logic       use_ovf;   // overflow_o reports the MSB overflow
    logic       slt;       // result is the signed less-than bit
  } dec_t;

  function automatic dec_t decode(input logic [3:0] ctrl);
    dec_t d;
    d = '0;
    d.legal = 1'b1;
    case (ctrl)
      4'b0000: d.op = 2'b00;
      4'b0001: d.op = 2'b01;
      4'b0010: begin
        d.op       = 2'b10;
        d.use_cout = 1'b1;
        d.use_ovf  = 1'b1;
      end
      4'b0110: begin
        d.binv     = 1'b1;
        d.op       = 2'b10;
        d.cin      = 1'b1;
        d.use_cout = 1'b1;
        d.use_ovf  = 1'b1;
      end
      4'b0111: begin
        d.binv     = 1'b1;
        d.op       = 2'b10;
        d.cin      = 1'b1;
        d.use_cout = 1'b1;
        d.slt      = 1'b1;
      end
      4'b1100: begin
        d.ainv = 1'b1;
        d.binv = 1'b1;
        d.op   = 2'b00;
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  state_t           r_state;
  state_t           w_next_state;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_ainv;
  logic             r_binv;
  logic [1:0]       r_op;
  logic             r_use_cout;
  logic             r_use_ovf;
  logic             r_slt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_cout;
  logic             r_ovf;
  logic             r_err;

  dec_t             w_dec;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nxt;
  logic [WIDTH-1:0] w_final;

  assign w_dec     = decode(ctrl_i);
  assign w_last    = (r_cnt == LAST_BIT);
  assign w_res_nxt = {sl_result_i, r_res[WIDTH-1:1]};
  // For SLT the MSB sum bit corrected by overflow is the true sign of A-B.
  assign w_final   = r_slt ? {{(WIDTH-1){1'b0}}, sl_set_i ^ sl_overflow_i}
                           : w_res_nxt;

  // Next-state and slice drive
  always_comb begin
    w_next_state = r_state;
    sl_src1_o    = 1'b0;
    sl_src2_o    = 1'b0;
    sl_less_o    = 1'b0;
    sl_ainv_o    = 1'b0;
    sl_binv_o    = 1'b0;
    sl_cin_o     = 1'b0;
    sl_op_o      = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_next_state = w_dec.legal ? S_RUN : S_FIN;
        end
      end
      S_RUN: begin
        sl_src1_o = r_a[0];
        sl_src2_o = r_b[0];
        sl_ainv_o = r_ainv;
        sl_binv_o = r_binv;
        sl_cin_o  = r_carry;
        sl_op_o   = r_op;
        if (w_last) begin
          w_next_state = S_FIN;
        end
      end
      S_FIN: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State, datapath and held outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_ainv     <= 1'b0;
      r_binv     <= 1'b0;
      r_op       <= 2'b00;
      r_use_cout <= 1'b0;
      r_use_ovf  <= 1'b0;
      r_slt      <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_a        <= src1_i;
            r_b        <= src2_i;
            r_res      <= '0;
            r_cnt      <= '0;
            r_carry    <= w_dec.cin;
            r_ainv     <= w_dec.ainv;
            r_binv     <= w_dec.binv;
            r_op       <= w_dec.op;
            r_use_cout <= w_dec.use_cout;
            r_use_ovf  <= w_dec.use_ovf;
            r_slt      <= w_dec.slt;
            // An illegal op skips RUN; the error result is visible in FIN.
            if (!w_dec.legal) begin
              r_result <= '0;
              r_zero   <= 1'b0;
              r_cout   <= 1'b0;
              r_ovf    <= 1'b0;
              r_err    <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_res   <= w_res_nxt;
          r_carry <= sl_cout_i;
          r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
          // The MSB slice outputs are captured straight into the held
          // outputs on the RUN->FIN edge, so they are valid with done_o.
          if (w_last) begin
            r_result <= w_final;
            r_zero   <= (w_final == '0);
            r_cout   <= r_use_cout & sl_cout_i;
            r_ovf    <= r_use_ovf & sl_overflow_i;
            r_err    <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy_o     = (r_state == S_RUN) || (r_state == S_FIN);
  assign done_o     = (r_state == S_FIN);
  assign err_o      = r_err;
  assign result_o   = r_result;
  assign zero_o     = r_zero;
  assign cout_o     = r_cout;
  assign overflow_o = r_ovf;

endmodule
